// File: rtl/iob_wb2iob_pkg.sv
// rtl/iob_wb2iob_pkg.sv - shared FSM states and Wishbone CTI/BTE codes for the WB-to-IOb bridge
package iob_wb2iob_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR = 2'b00;
   localparam logic [1:0] BTE_WRAP4  = 2'b01;
   localparam logic [1:0] BTE_WRAP8  = 2'b10;
   localparam logic [1:0] BTE_WRAP16 = 2'b11;

endpackage

// File: rtl/iob_wb2iob_addr_wrap.sv
// rtl/iob_wb2iob_addr_wrap.sv - combinational next-beat address for linear and wrapping bursts
module iob_wb2iob_addr_wrap
   import iob_wb2iob_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        bte,
   output logic [ADDR_W-1:0] next_addr
);

   localparam logic [ADDR_W-1:0] BYTES  = ADDR_W'(DATA_W / 8);
   localparam logic [ADDR_W-1:0] MASK4  = ADDR_W'(4 * (DATA_W / 8) - 1);
   localparam logic [ADDR_W-1:0] MASK8  = ADDR_W'(8 * (DATA_W / 8) - 1);
   localparam logic [ADDR_W-1:0] MASK16 = ADDR_W'(16 * (DATA_W / 8) - 1);

   logic [ADDR_W-1:0] incr;
   logic [ADDR_W-1:0] mask;

   assign incr = addr + BYTES;

   // Only the masked low bits take the incremented value; linear uses a full mask
   always_comb begin
      mask = '1;
      case (bte)
         BTE_LINEAR: mask = '1;
         BTE_WRAP4:  mask = MASK4;
         BTE_WRAP8:  mask = MASK8;
         BTE_WRAP16: mask = MASK16;
      endcase
      next_addr = (addr & ~mask) | (incr & mask);
   end

endmodule

// File: rtl/iob_wb2iob_bridge.sv
// rtl/iob_wb2iob_bridge.sv - Wishbone B3 slave to IOb master bridge with timeout; bursts under IOB_WB2IOB_BURST_EN
module iob_wb2iob_bridge
   import iob_wb2iob_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TOUT_W = 8,
   parameter int ERRC_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W-1:0]   wb_adr_i,
   input  logic [DATA_W/8-1:0] wb_sel_i,
   input  logic                wb_we_i,
   input  logic                wb_cyc_i,
   input  logic                wb_stb_i,
   input  logic [2:0]          wb_cti_i,
   input  logic [1:0]          wb_bte_i,
   input  logic [DATA_W-1:0]   wb_dat_i,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic                wb_ack_o,
   output logic                wb_err_o,
   output logic                m_valid,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_ready,
   output logic [ERRC_W-1:0]   err_cnt_o
);

   localparam logic [TOUT_W-1:0] TOUT_MAX = '1;
   localparam logic [TOUT_W-1:0] TOUT_ONE = TOUT_W'(1);
   localparam logic [ERRC_W-1:0] ERRC_ONE = ERRC_W'(1);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   next_addr;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W/8-1:0] wstrb_q;
   logic [TOUT_W-1:0]   tcnt;
   logic                aborted_q;
   logic                aborted_now;
   logic                burst_cont;
   logic                start;

`ifdef IOB_WB2IOB_BURST_EN
   iob_wb2iob_addr_wrap #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_addr_wrap (
      .addr      (addr_q),
      .bte       (wb_bte_i),
      .next_addr (next_addr)
   );

   assign burst_cont = (state == ST_ACK) && wb_cyc_i && wb_stb_i && (wb_cti_i == CTI_INCR);
`else
   logic unused_burst;
   assign unused_burst = ^{wb_cti_i, wb_bte_i};
   assign next_addr    = addr_q;
   assign burst_cont   = 1'b0;
`endif

   assign aborted_now = aborted_q || !wb_cyc_i;
   assign start       = ((state == ST_IDLE) && wb_cyc_i && wb_stb_i) || burst_cont;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      m_valid   = 1'b0;
      m_addr    = addr_q;
      m_wdata   = wdata_q;
      m_wstrb   = wstrb_q;
      wb_ack_o  = 1'b0;
      wb_err_o  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i) state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            // The last counter value already withdraws the request, but m_ready still wins
            m_valid = (tcnt != TOUT_MAX);
            if (m_ready)               state_nxt = aborted_now ? ST_IDLE : ST_ACK;
            else if (tcnt == TOUT_MAX) state_nxt = aborted_now ? ST_IDLE : ST_ERR;
         end
         ST_ACK: begin
            wb_ack_o  = 1'b1;
            state_nxt = ST_IDLE;
            if (burst_cont) begin
               m_valid   = 1'b1;
               m_addr    = next_addr;
               m_wdata   = wb_dat_i;
               m_wstrb   = wb_we_i ? wb_sel_i : '0;
               state_nxt = ST_ACCESS;
            end
         end
         ST_ERR: begin
            wb_err_o  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         tcnt      <= '0;
         aborted_q <= 1'b0;
         wb_dat_o  <= '0;
         err_cnt_o <= '0;
      end else if (start) begin
         addr_q    <= (state == ST_IDLE) ? wb_adr_i : next_addr;
         wdata_q   <= wb_dat_i;
         wstrb_q   <= wb_we_i ? wb_sel_i : '0;
         tcnt      <= '0;
         aborted_q <= 1'b0;
      end else if (state == ST_ACCESS) begin
         if (tcnt != TOUT_MAX) tcnt <= tcnt + TOUT_ONE;
         if (!wb_cyc_i) aborted_q <= 1'b1;
         if (m_ready && !aborted_now && (wstrb_q == '0)) wb_dat_o <= m_rdata;
         if (!m_ready && (tcnt == TOUT_MAX) && (err_cnt_o != '1))
            err_cnt_o <= err_cnt_o + ERRC_ONE;
      end
   end

endmodule

// File: tb/tb_iob_wb2iob_bridge.sv
// tb/tb_iob_wb2iob_bridge.sv - directed self-checking bench for iob_wb2iob_bridge (TOUT_W=4)
module tb_iob_wb2iob_bridge;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TOUT_W = 4;
   localparam int ERRC_W = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [ADDR_W-1:0]   wb_adr_i;
   logic [DATA_W/8-1:0] wb_sel_i;
   logic                wb_we_i, wb_cyc_i, wb_stb_i;
   logic [2:0]          wb_cti_i;
   logic [1:0]          wb_bte_i;
   logic [DATA_W-1:0]   wb_dat_i;
   logic [DATA_W-1:0]   wb_dat_o;
   logic                wb_ack_o, wb_err_o;
   logic                m_valid;
   logic [ADDR_W-1:0]   m_addr;
   logic [DATA_W-1:0]   m_wdata;
   logic [DATA_W/8-1:0] m_wstrb;
   logic [DATA_W-1:0]   m_rdata;
   logic                m_ready;
   logic [ERRC_W-1:0]   err_cnt_o;

   int n_cmp = 0;
   int n_mis = 0;

   iob_wb2iob_bridge #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TOUT_W (TOUT_W),
      .ERRC_W (ERRC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_adr_i  (wb_adr_i),
      .wb_sel_i  (wb_sel_i),
      .wb_we_i   (wb_we_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_stb_i  (wb_stb_i),
      .wb_cti_i  (wb_cti_i),
      .wb_bte_i  (wb_bte_i),
      .wb_dat_i  (wb_dat_i),
      .wb_dat_o  (wb_dat_o),
      .wb_ack_o  (wb_ack_o),
      .wb_err_o  (wb_err_o),
      .m_valid   (m_valid),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .m_rdata   (m_rdata),
      .m_ready   (m_ready),
      .err_cnt_o (err_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each call lands 2 time units after a rising edge: the start of a new cycle
   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_bus();
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      wb_cti_i = 3'b000;
      wb_bte_i = 2'b00;
   endtask

   task automatic start_req(input logic [31:0] adr, input logic we, input logic [31:0] dat);
      wb_adr_i = adr;
      wb_we_i  = we;
      wb_dat_i = dat;
      wb_sel_i = 4'hF;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
   endtask

   // Timeout with stb in cycle 0: m_valid low in cycle 16, wb_err_o in cycle 17
   task automatic do_timeout(input logic [31:0] adr, input logic [15:0] exp_cnt);
      m_ready = 1'b0;
      start_req(adr, 1'b0, 32'h0);
      nxt();
      chk("tout_valid_c1", m_valid, 1'b1);
      for (int c = 2; c <= 15; c++) nxt();
      chk("tout_valid_c15", m_valid, 1'b1);
      nxt();
      chk("tout_valid_c16", m_valid, 1'b0);
      chk("tout_err_c16", wb_err_o, 1'b0);
      nxt();
      chk("tout_err_c17", wb_err_o, 1'b1);
      chk("tout_cnt", err_cnt_o, exp_cnt);
      idle_bus();
      nxt();
      chk("tout_err_c18", wb_err_o, 1'b0);
   endtask

   initial begin
      rst_n    = 1'b0;
      idle_bus();
      wb_adr_i = '0;
      wb_sel_i = '0;
      wb_dat_i = '0;
      m_rdata  = '0;
      m_ready  = 1'b0;
      #3;
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_addr", m_addr, 32'h0);
      chk("rst_wstrb", m_wstrb, 4'h0);
      chk("rst_ack", wb_ack_o, 1'b0);
      chk("rst_err", wb_err_o, 1'b0);
      chk("rst_dat", wb_dat_o, 32'h0);
      chk("rst_cnt", err_cnt_o, 16'h0);
      nxt();
      nxt();
      rst_n = 1'b1;
      nxt();

      // Single write, m_ready tied high
      m_ready = 1'b1;
      start_req(32'h100, 1'b1, 32'hDEADBEEF);
      #1 chk("wr_valid_c0", m_valid, 1'b0);
      nxt();
      chk("wr_valid_c1", m_valid, 1'b1);
      chk("wr_addr_c1", m_addr, 32'h100);
      chk("wr_wstrb_c1", m_wstrb, 4'hF);
      chk("wr_wdata_c1", m_wdata, 32'hDEADBEEF);
      chk("wr_ack_c1", wb_ack_o, 1'b0);
      nxt();
      chk("wr_ack_c2", wb_ack_o, 1'b1);
      chk("wr_valid_c2", m_valid, 1'b0);
      idle_bus();
      nxt();
      chk("wr_ack_c3", wb_ack_o, 1'b0);

      // Read with 3 stall cycles, m_ready in cycle 4
      m_ready = 1'b0;
      start_req(32'h40, 1'b0, 32'h0);
      nxt();
      chk("rd_valid_c1", m_valid, 1'b1);
      chk("rd_wstrb_c1", m_wstrb, 4'h0);
      chk("rd_addr_c1", m_addr, 32'h40);
      nxt();
      nxt();
      chk("rd_valid_c3", m_valid, 1'b1);
      nxt();
      chk("rd_ack_c4", wb_ack_o, 1'b0);
      m_ready = 1'b1;
      m_rdata = 32'h12345678;
      nxt();
      chk("rd_ack_c5", wb_ack_o, 1'b1);
      chk("rd_dat_c5", wb_dat_o, 32'h12345678);
      m_ready = 1'b0;
      m_rdata = 32'h0;
      idle_bus();
      nxt();
      chk("rd_ack_c6", wb_ack_o, 1'b0);
      chk("rd_dat_hold", wb_dat_o, 32'h12345678);

      // Three timeouts accumulate in the error counter
      do_timeout(32'h500, 16'd1);
      do_timeout(32'h504, 16'd2);
      do_timeout(32'h508, 16'd3);
      chk("tout_dat_hold", wb_dat_o, 32'h12345678);

      // Abort: cyc dropped in cycle 2, m_ready arrives in cycle 4
      m_ready = 1'b0;
      start_req(32'h80, 1'b0, 32'h0);
      nxt();
      chk("ab_valid_c1", m_valid, 1'b1);
      nxt();
      idle_bus();
      nxt();
      chk("ab_valid_c3", m_valid, 1'b1);
      chk("ab_ack_c3", wb_ack_o, 1'b0);
      nxt();
      m_ready = 1'b1;
      m_rdata = 32'hCAFEF00D;
      nxt();
      chk("ab_ack_c5", wb_ack_o, 1'b0);
      chk("ab_err_c5", wb_err_o, 1'b0);
      chk("ab_valid_c5", m_valid, 1'b0);
      chk("ab_dat_c5", wb_dat_o, 32'h12345678);
      m_ready = 1'b0;
      nxt();
      chk("ab_ack_c6", wb_ack_o, 1'b0);
      chk("ab_cnt", err_cnt_o, 16'd3);

      // m_ready exactly at the timeout limit completes normally
      start_req(32'h84, 1'b0, 32'h0);
      for (int c = 1; c <= 16; c++) nxt();
      chk("lim_valid_c16", m_valid, 1'b0);
      m_ready = 1'b1;
      m_rdata = 32'h55AA55AA;
      nxt();
      chk("lim_ack_c17", wb_ack_o, 1'b1);
      chk("lim_err_c17", wb_err_o, 1'b0);
      chk("lim_dat_c17", wb_dat_o, 32'h55AA55AA);
      chk("lim_cnt", err_cnt_o, 16'd3);
      m_ready = 1'b0;
      idle_bus();
      nxt();
      chk("lim_err_c18", wb_err_o, 1'b0);

      // Reset asserted in the middle of an access
      start_req(32'h200, 1'b1, 32'h11223344);
      nxt();
      nxt();
      chk("mr_valid_c2", m_valid, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("mr_valid", m_valid, 1'b0);
      chk("mr_addr", m_addr, 32'h0);
      chk("mr_wstrb", m_wstrb, 4'h0);
      chk("mr_wdata", m_wdata, 32'h0);
      chk("mr_dat", wb_dat_o, 32'h0);
      chk("mr_cnt", err_cnt_o, 16'h0);
      idle_bus();
      nxt();
      rst_n = 1'b1;
      nxt();
      m_ready = 1'b1;
      start_req(32'h300, 1'b1, 32'hA5A5A5A5);
      nxt();
      chk("mr2_addr_c1", m_addr, 32'h300);
      chk("mr2_valid_c1", m_valid, 1'b1);
      nxt();
      chk("mr2_ack_c2", wb_ack_o, 1'b1);
      idle_bus();
      m_ready = 1'b0;
      nxt();

`ifdef IOB_WB2IOB_BURST_EN
      // 4-beat wrap-4 read burst from 0x18
      m_ready  = 1'b1;
      m_rdata  = 32'h0BADCAFE;
      start_req(32'h18, 1'b0, 32'h0);
      wb_cti_i = 3'b010;
      wb_bte_i = 2'b01;
      nxt();
      chk("bu_addr_c1", m_addr, 32'h18);
      nxt();
      #1;
      chk("bu_ack_c2", wb_ack_o, 1'b1);
      chk("bu_valid_c2", m_valid, 1'b1);
      chk("bu_addr_c2", m_addr, 32'h1C);
      nxt();
      chk("bu_addr_c3", m_addr, 32'h1C);
      nxt();
      #1;
      chk("bu_addr_c4", m_addr, 32'h10);
      chk("bu_valid_c4", m_valid, 1'b1);
      nxt();
      nxt();
      #1;
      chk("bu_addr_c6", m_addr, 32'h14);
      chk("bu_valid_c6", m_valid, 1'b1);
      nxt();
      wb_cti_i = 3'b111;
      chk("bu_addr_c7", m_addr, 32'h14);
      nxt();
      #1;
      chk("bu_ack_c8", wb_ack_o, 1'b1);
      chk("bu_valid_c8", m_valid, 1'b0);
      chk("bu_dat_c8", wb_dat_o, 32'h0BADCAFE);
      idle_bus();
      m_ready = 1'b0;
      nxt();
      chk("bu_ack_c9", wb_ack_o, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/iob_wb2iob_bridge.md
# iob_wb2iob_bridge

Wishbone-slave to IOb-master bridge, successor to the fixed single-beat Wishbone-to-IOb converter used behind the Ethernet MAC's DMA master. It accepts Wishbone B3 cycles from a master such as the MAC DMA engine and issues IOb memory requests. It is parametrised in address/data width and adds three things the single-beat converter lacks: a response timeout, a saturating error counter, and optional incrementing/wrapping burst support.

## Interface
- ADDR_W, 32: byte-address width, both sides.
- DATA_W, 32: data width; a multiple of 8, at least 16.
- TOUT_W, 8: timeout counter width; limit is 2^TOUT_W-1 cycles.
- ERRC_W, 16: error counter width.
- clk  in  1  single clock, both sides.
- rst_n  in  1  asynchronous, active-low reset.
- wb_adr_i  in  ADDR_W  byte address.
- wb_sel_i  in  DATA_W/8  byte selects.
- wb_we_i, wb_cyc_i, wb_stb_i  in  1 each  Wishbone control.
- wb_cti_i  in  3  cycle type. Used only with burst support compiled in.
- wb_bte_i  in  2  burst type. Used only with burst support compiled in.
- wb_dat_i  in  DATA_W  write data.
- wb_dat_o  out  DATA_W  registered read data.
- wb_ack_o, wb_err_o  out  1 each  single-cycle termination pulses.
- m_valid  out  1  IOb request.
- m_addr  out  ADDR_W  IOb address.
- m_wdata  out  DATA_W  IOb write data.
- m_wstrb  out  DATA_W/8  IOb write strobes; 0 means read.
- m_rdata  in  DATA_W  IOb read data, valid in the m_ready cycle.
- m_ready  in  1  IOb accept/complete.
- err_cnt_o  out  ERRC_W  saturating count of timeouts.

## Operation
- FSM states: IDLE, ACCESS, ACK, ERR.
- IDLE, on wb_cyc_i & wb_stb_i:
  - Latch address, data and sel.
  - m_wstrb = wb_we_i ? wb_sel_i : 0.
  - Next state ACCESS.
- ACCESS:
  - m_valid=1; m_addr, m_wdata and m_wstrb held stable.
  - Timeout counter cleared on entry and incremented each cycle.
  - On m_ready: on a read, register m_rdata into wb_dat_o; next state ACK.
  - Counter reaching 2^TOUT_W-1 without m_ready: drop m_valid, increment err_cnt_o (saturating at all-ones), next state ERR.
- ACK: wb_ack_o=1 for one cycle, then IDLE. The burst exception is below.
- ERR: wb_err_o=1 for one cycle, then IDLE.
- wb_cyc_i dropped while in ACCESS:
  - The IOb request is not aborted; it runs to m_ready or timeout.
  - Its result is discarded; no ack or err is issued.
  - Next state IDLE.
- wb_dat_o keeps its last read value until the next read completes.
- m_ready outside ACCESS is ignored.

## Timing
- Reset values: m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, wb_dat_o=0, wb_ack_o=0, wb_err_o=0, err_cnt_o=0, state IDLE.
- Reset asserted mid-transfer clears all of the above immediately; the in-flight request is abandoned.
- Single access, stb in cycle 0:
  - m_valid from cycle 1.
  - With m_ready in cycle 1, wb_ack_o in cycle 2.
  - Minimum latency is 2 cycles; each stall cycle adds 1.
- Timeout with stb in cycle 0: wb_err_o in cycle 1+2^TOUT_W-1+1.
- m_ready and the timeout limit in the same cycle: m_ready wins; the access completes normally and no error is counted.

## Configuration
- Macro: IOB_WB2IOB_BURST_EN.
- Defined:
  - In ACK, if wb_cti_i==3'b010 and wb_cyc_i & wb_stb_i are still high, the next beat's IOb request is issued in the same cycle as the ack, and the FSM goes directly to ACCESS.
  - Next address = current address + DATA_W/8.
  - Wrapping by wb_bte_i: 00 linear; 01 wraps in a 4-beat block; 10 in an 8-beat block; 11 in a 16-beat block. Only the low log2(beats·DATA_W/8) address bits change.
  - wb_cti_i==3'b111 or 3'b000 ends the burst through IDLE.
  - Steady burst throughput: one beat per 2 cycles when m_ready is immediate.
- Undefined: wb_cti_i and wb_bte_i are ignored, and every beat passes through IDLE.

## Structure
- Shared package/header iob_wb2iob_pkg:
  - state encodings;
  - CTI constants CLASSIC=000, INCR=010, EOB=111;
  - BTE constants.
- One sub-module, iob_wb2iob_addr_wrap: combinational next-address generator (address, bte, DATA_W) → next address. It is instantiated only with IOB_WB2IOB_BURST_EN.

## Test plan
- Single write:
  - Stimulus: adr=0x100, dat=0xDEADBEEF, sel=0xF; m_ready tied 1.
  - Response: m_valid in cycle 1 with m_wstrb=0xF; wb_ack_o in cycle 2 only.
- Read with stall:
  - Stimulus: adr=0x40; m_ready raised after 3 wait cycles with m_rdata=0x12345678.
  - Response: m_wstrb=0; wb_dat_o=0x12345678 with wb_ack_o exactly 1 cycle after m_ready.
- Timeout:
  - Stimulus: TOUT_W=4, m_ready held 0.
  - Response: wb_err_o in cycle 17; err_cnt_o=1; m_valid low from cycle 16. Repeating 3 times gives err_cnt_o=3.
- Burst (macro defined):
  - Stimulus: read burst, cti=010, bte=01, start adr=0x18, 4 beats.
  - Response: m_addr sequence 0x18, 0x1C, 0x10, 0x14; each next m_valid in its ack cycle.
- Abort:
  - Stimulus: wb_cyc_i dropped in cycle 2 of a stalled access.
  - Response: m_valid held until m_ready; no ack or err pulse; FSM returns to IDLE.
- Reset mid-access:
  - Stimulus: rst_n pulsed low during ACCESS.
  - Response: all outputs 0 asynchronously; the next stb is served normally.
